xy_mod_counter_fsm: RTL and testbench
=====================================

Name: xy_mod_counter_fsm

Overview:
- Parametrised successor to the two-input (X, Y) lab state machine.
- Control inputs are the same X/Y pair; X is count enable, Y is direction.
- The single-bit state is generalised to a WIDTH-bit modulo-MODULUS up/down counter with a 4-state mode FSM, synchronous load, wrap or saturate mode, and a registered terminal-count flag A.
- Intended as the reusable counter/sequencer for later labs. Driven by the same style of CLK/RST/X/Y bench.

Parameters:
- WIDTH, 4: counter width in bits.
- MODULUS, 10: count range is 0 to MODULUS-1. Legal range is 2 <= MODULUS <= 2**WIDTH. Elaboration fails (error) outside this range.
- SATURATE, 0: 0 means wrap at the boundaries; 1 means clamp at the boundaries.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- X  input  1  count enable.
- Y  input  1  direction: 0 = up, 1 = down.
- LOAD  input  1  synchronous load of D.
- D  input  WIDTH  load value.
- Q  output  WIDTH  current count, registered.
- A  output  1  terminal-count flag, registered, one cycle per event.
- STATE  output  2  mode FSM state, registered.

Behaviour:
- Reset:
  - RST=1 immediately forces Q=0, A=0, STATE=IDLE, with no clock edge needed.
  - Outputs are held while RST=1.
  - Operation resumes on the first rising edge after RST deasserts.
  - Reset mid-count discards any pending step.
- FSM encoding: IDLE=00, UP=01, DOWN=10, HOLD=11.
- Priority at each rising edge: LOAD > X > hold.
- LOAD=1:
  - Q <= D, clamped to MODULUS-1 if D >= MODULUS.
  - STATE <= IDLE, A <= 0.
  - X and Y are ignored that cycle.
- LOAD=0, X=1, Y=0:
  - STATE <= UP.
  - Q <= Q+1.
  - If Q == MODULUS-1: wrap mode gives Q <= 0; saturate mode gives Q <= MODULUS-1. A <= 1 in both modes.
- LOAD=0, X=1, Y=1:
  - STATE <= DOWN.
  - Q <= Q-1.
  - If Q == 0: wrap mode gives Q <= MODULUS-1; saturate mode gives Q <= 0. A <= 1 in both modes.
- LOAD=0, X=0:
  - If STATE is IDLE, it stays IDLE; otherwise STATE <= HOLD.
  - Q holds; A <= 0.
- A timing:
  - A is high for exactly the cycle following the boundary step, i.e. concurrently with the wrapped or clamped Q.
  - A is 0 on every non-boundary cycle.
  - In saturate mode, every further step attempted at the limit re-asserts A.
- Latency: one cycle from X/Y/LOAD sampled at an edge to Q/STATE/A updated. No combinational input-to-output paths.
- Direction change takes effect immediately (UP to DOWN with no intermediate HOLD).
- Arithmetic: internal compare and increment use WIDTH+1 bits, so MODULUS = 2**WIDTH wraps correctly without overflow aliasing.

Optional Feature:
- Macro: XY_FSM_WRAP_STAT_EN.
- Defined:
  - Adds output port WRAPS, 8 bits, registered.
  - WRAPS increments on every cycle in which A is set, saturating at 255.
  - WRAPS clears on RST (asynchronously) and on LOAD.
- Undefined: no WRAPS port, no associated logic. All other behaviour is identical.

Test Plan:
- Reset: RST=1 asserted mid-cycle with Q=5 -> Q=0, A=0, STATE=00 immediately, before any clock edge. Q stays 0 while RST=1.
- Up-count (defaults): X=1, Y=0 for 12 edges from Q=0 -> Q runs 1..9,0,1,2. A=1 only in the cycle where Q=0. STATE=01 throughout.
- Down-count: from Q=0, X=1, Y=1 -> Q=9, A=1, STATE=10. A further 9 edges -> Q=0, A=0 during the run.
- Hold: count up to Q=7, then X=0 for 5 edges -> STATE=11, Q=7, A=0. After reset, X=0 gives STATE=00.
- Load: LOAD=1, D=12, X=1 -> Q=9 (clamped), STATE=00, A=0. Next edge with X=1, Y=0 -> Q=0, A=1.
- Saturate (SATURATE=1): from Q=8, up for 3 edges -> Q=9,9,9 and A=0,1,1. With XY_FSM_WRAP_STAT_EN defined -> WRAPS=2.

Source files
------------

// File: rtl/xy_mod_counter_fsm.sv
// Modulo-MODULUS up/down counter with IDLE/UP/DOWN/HOLD mode FSM and registered terminal-count flag.
// Optional XY_FSM_WRAP_STAT_EN adds an 8-bit saturating WRAPS count of terminal-count events.
module xy_mod_counter_fsm #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter int SATURATE = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             X,
    input  logic             Y,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             A,
    output logic [1:0]       STATE
`ifdef XY_FSM_WRAP_STAT_EN
    ,
    output logic [7:0]       WRAPS
`endif
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_UP   = 2'b01;
    localparam logic [1:0] ST_DOWN = 2'b10;
    localparam logic [1:0] ST_HOLD = 2'b11;

    // One extra bit keeps MODULUS == 2**WIDTH representable in compares.
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAX_Q   = MAX_EXT[WIDTH-1:0];

    generate
        if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
            $error("xy_mod_counter_fsm: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
    endgenerate

    logic [WIDTH:0]   q_ext, d_ext;
    logic [WIDTH-1:0] q_nxt;
    logic             a_nxt;
    logic [1:0]       st_nxt;

    assign q_ext = {1'b0, Q};
    assign d_ext = {1'b0, D};

    always_comb begin
        q_nxt  = Q;
        a_nxt  = 1'b0;
        st_nxt = STATE;
        if (LOAD) begin
            q_nxt  = (d_ext > MAX_EXT) ? MAX_Q : D;
            st_nxt = ST_IDLE;
        end else if (X && !Y) begin
            st_nxt = ST_UP;
            if (q_ext == MAX_EXT) begin
                a_nxt = 1'b1;
                q_nxt = (SATURATE != 0) ? MAX_Q : '0;
            end else begin
                q_nxt = Q + WIDTH'(1);
            end
        end else if (X && Y) begin
            st_nxt = ST_DOWN;
            if (q_ext == '0) begin
                a_nxt = 1'b1;
                q_nxt = (SATURATE != 0) ? '0 : MAX_Q;
            end else begin
                q_nxt = Q - WIDTH'(1);
            end
        end else begin
            st_nxt = (STATE == ST_IDLE) ? ST_IDLE : ST_HOLD;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Q     <= '0;
            A     <= 1'b0;
            STATE <= ST_IDLE;
        end else begin
            Q     <= q_nxt;
            A     <= a_nxt;
            STATE <= st_nxt;
        end
    end

`ifdef XY_FSM_WRAP_STAT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            WRAPS <= '0;
        end else if (LOAD) begin
            WRAPS <= '0;
        end else if (a_nxt && WRAPS != 8'hFF) begin
            WRAPS <= WRAPS + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_xy_mod_counter_fsm.sv
// Scoreboard bench: a wrap instance and a saturate instance share stimulus; expectations
// are queued at drive time and popped by a monitor one step after each rising edge.
module tb_xy_mod_counter_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       x = 1'b0, y = 1'b0, load = 1'b0;
    logic [3:0] d = '0;
    logic [3:0] q0, q1;
    logic       a0, a1;
    logic [1:0] s0, s1;
`ifdef XY_FSM_WRAP_STAT_EN
    logic [7:0] w0, w1;
`endif

    always #5 clk = ~clk;

    xy_mod_counter_fsm #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_wrap (
        .CLK(clk), .RST(rst), .X(x), .Y(y), .LOAD(load), .D(d),
        .Q(q0), .A(a0), .STATE(s0)
`ifdef XY_FSM_WRAP_STAT_EN
        , .WRAPS(w0)
`endif
    );

    xy_mod_counter_fsm #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_sat (
        .CLK(clk), .RST(rst), .X(x), .Y(y), .LOAD(load), .D(d),
        .Q(q1), .A(a1), .STATE(s1)
`ifdef XY_FSM_WRAP_STAT_EN
        , .WRAPS(w1)
`endif
    );

    typedef struct {
        int         tag;
        logic [3:0] q0; logic a0; logic [1:0] s0;
        bit         c1;
        logic [3:0] q1; logic a1; logic [1:0] s1;
        bit         cw;
        logic [7:0] w0; logic [7:0] w1;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   tag = 0;

    task automatic check(input string nm, input int t, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s tag=%0d got %0d want %0d", nm, t, act, exp);
        end
    endtask

    // Monitor: outputs are valid every cycle, so pop one expectation per edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("q0", e.tag, int'(q0), int'(e.q0));
            check("a0", e.tag, int'(a0), int'(e.a0));
            check("s0", e.tag, int'(s0), int'(e.s0));
            if (e.c1) begin
                check("q1", e.tag, int'(q1), int'(e.q1));
                check("a1", e.tag, int'(a1), int'(e.a1));
                check("s1", e.tag, int'(s1), int'(e.s1));
            end
`ifdef XY_FSM_WRAP_STAT_EN
            if (e.cw) begin
                check("wraps0", e.tag, int'(w0), int'(e.w0));
                check("wraps1", e.tag, int'(w1), int'(e.w1));
            end
`endif
        end
    end

    task automatic step(input logic ld, input logic [3:0] dv, input logic xv, input logic yv,
                        input logic [3:0] eq0, input logic ea0, input logic [1:0] es0,
                        input bit c1, input logic [3:0] eq1, input logic ea1, input logic [1:0] es1,
                        input bit cw, input logic [7:0] ew0, input logic [7:0] ew1);
        exp_t e;
        @(negedge clk);
        load = ld; d = dv; x = xv; y = yv;
        tag++;
        e.tag = tag;
        e.q0 = eq0; e.a0 = ea0; e.s0 = es0;
        e.c1 = c1; e.q1 = eq1; e.a1 = ea1; e.s1 = es1;
        e.cw = cw; e.w0 = ew0; e.w1 = ew1;
        sb.push_back(e);
    endtask

    task automatic st0(input logic ld, input logic [3:0] dv, input logic xv, input logic yv,
                       input logic [3:0] eq, input logic ea, input logic [1:0] es);
        step(ld, dv, xv, yv, eq, ea, es, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 8'd0, 8'd0);
    endtask

    initial begin
        // Power-on reset
        #12;
        check("rst_q", 0, int'(q0), 0);
        check("rst_st", 0, int'(s0), 0);
        @(negedge clk); rst = 1'b0;

        for (int i = 1; i <= 5; i++) st0(1'b0, 4'd0, 1'b1, 1'b0, 4'(i), 1'b0, 2'b01);
        @(negedge clk);
        x = 1'b0;
        check("pre_rst_q", 0, int'(q0), 5);
        // Asynchronous reset between edges
        #2 rst = 1'b1;
        #1;
        check("async_q", 0, int'(q0), 0);
        check("async_a", 0, int'(a0), 0);
        check("async_st", 0, int'(s0), 0);
        x = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("held_q", 0, int'(q0), 0);
        check("held_st", 0, int'(s0), 0);
        @(negedge clk); rst = 1'b0; x = 1'b0;

        // Idle with X=0 stays IDLE
        st0(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00);

        // Up-count through wrap
        for (int i = 1; i <= 12; i++)
            st0(1'b0, 4'd0, 1'b1, 1'b0, 4'(i % 10), (i == 10), 2'b01);

        // Load 0, then down-count through underflow
        st0(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00);
        st0(1'b0, 4'd0, 1'b1, 1'b1, 4'd9, 1'b1, 2'b10);
        for (int i = 8; i >= 0; i--) st0(1'b0, 4'd0, 1'b1, 1'b1, 4'(i), 1'b0, 2'b10);

        // Hold at 7
        for (int i = 1; i <= 7; i++) st0(1'b0, 4'd0, 1'b1, 1'b0, 4'(i), 1'b0, 2'b01);
        for (int i = 0; i < 5; i++) st0(1'b0, 4'd0, 1'b0, 1'b0, 4'd7, 1'b0, 2'b11);

        // Clamped load ignores X, then wraps on next up
        st0(1'b1, 4'd12, 1'b1, 1'b0, 4'd9, 1'b0, 2'b00);
        st0(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 2'b01);

        // Immediate direction change
        st0(1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b0, 2'b01);
        st0(1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 2'b10);
        st0(1'b0, 4'd0, 1'b1, 1'b1, 4'd9, 1'b1, 2'b10);

        // Wrap vs saturate side by side
        step(1'b1, 4'd8, 1'b0, 1'b0, 4'd8, 1'b0, 2'b00, 1'b1, 4'd8, 1'b0, 2'b00, 1'b1, 8'd0, 8'd0);
        step(1'b0, 4'd0, 1'b1, 1'b0, 4'd9, 1'b0, 2'b01, 1'b1, 4'd9, 1'b0, 2'b01, 1'b1, 8'd0, 8'd0);
        step(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 2'b01, 1'b1, 4'd9, 1'b1, 2'b01, 1'b1, 8'd1, 8'd1);
        step(1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b0, 2'b01, 1'b1, 4'd9, 1'b1, 2'b01, 1'b1, 8'd1, 8'd2);
        step(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 1'b1, 4'd0, 1'b0, 2'b00, 1'b1, 8'd0, 8'd0);
        step(1'b0, 4'd0, 1'b1, 1'b1, 4'd9, 1'b1, 2'b10, 1'b1, 4'd0, 1'b1, 2'b10, 1'b1, 8'd1, 8'd1);
        step(1'b0, 4'd0, 1'b0, 1'b0, 4'd9, 1'b0, 2'b11, 1'b1, 4'd0, 1'b0, 2'b11, 1'b1, 8'd1, 8'd1);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        check("sb_drained", 0, sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
